// File: rtl/ahb_fill_sequencer.sv
// AHB-Lite read master that turns one I-cache miss request into a WRAP4 line fill
// or a SINGLE uncached word fetch, and assembles the returned words into a 128-bit line.
module ahb_fill_sequencer (
  input  logic         clk,
  input  logic         rstn,
  // Request side: handshake is valid/ready. A request is taken on the rising
  // edge where req_valid and req_ready are both 1; req_ready is 1 only in IDLE.
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [31:0]  req_addr,
  input  logic         req_wrap,
  // AHB-Lite master
  output logic [31:0]  haddr,
  output logic [1:0]   htrans,
  output logic [2:0]   hburst,
  output logic         hwrite,
  output logic [2:0]   hsize,
  input  logic [31:0]  hrdata,
  input  logic         hready,
  input  logic         hresp,
  // Fill result
  output logic         fill_valid,
  output logic [31:0]  fill_addr,
  output logic [127:0] line_data,
  output logic         fill_err,
  // Debug view of the sequencer state
  output logic [2:0]   dbg_state
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_BURST = 3'd2,
    S_LAST  = 3'd3,
    S_ERR   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [29:0]    r_word;
  logic           r_wrap;
  logic [1:0]     r_beat;
  logic [1:0]     r_dbeat;
  logic           r_err;
  logic [31:0]    r_fill_addr;
  logic [127:0]   r_line;

  logic           w_accept;
  logic           w_addr_done;
  logic           w_data_phase;
  logic           w_capture;
  logic           w_error;
  logic [1:0]     w_addr_off;
  logic [1:0]     w_data_word;
  logic           w_unused;

  // Byte offset of the request is architecturally ignored.
  assign w_unused = &{1'b0, req_addr[1:0]};

  assign w_accept     = (r_state == S_IDLE) && req_valid;
  assign w_addr_done  = ((r_state == S_ADDR) || (r_state == S_BURST)) && hready;
  // Every BURST or LAST cycle carries the data phase of the previous beat.
  assign w_data_phase = (r_state == S_BURST) || (r_state == S_LAST);
  assign w_capture    = w_data_phase && hready;
  assign w_error      = w_data_phase && hresp && !hready;

  // 2-bit offsets wrap inside the 16-byte line and never carry into bit 4.
  assign w_addr_off  = r_word[1:0] + r_beat;
  assign w_data_word = r_word[1:0] + r_dbeat;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_ADDR;
      S_ADDR:  if (hready) w_next = r_wrap ? S_BURST : S_LAST;
      S_BURST: begin
        if (w_error)                     w_next = S_ERR;
        else if (hready && r_beat == 2'd3) w_next = S_LAST;
      end
      S_LAST: begin
        if (w_error)     w_next = S_ERR;
        else if (hready) w_next = S_DONE;
      end
      S_ERR:   if (hready) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_word      <= '0;
      r_wrap      <= 1'b0;
      r_beat      <= '0;
      r_dbeat     <= '0;
      r_err       <= 1'b0;
      r_fill_addr <= '0;
      r_line      <= '0;
    end else begin
      if (w_accept) begin
        r_word      <= req_addr[31:2];
        r_wrap      <= req_wrap;
        r_beat      <= '0;
        r_dbeat     <= '0;
        r_err       <= 1'b0;
        r_line      <= '0;
        r_fill_addr <= req_wrap ? {req_addr[31:4], 4'b0000} : {req_addr[31:2], 2'b00};
      end else begin
        // Beat 3 stays on the bus through LAST, so the counter saturates there.
        if (w_addr_done && r_wrap && (r_beat != 2'd3)) begin
          r_beat <= r_beat + 2'd1;
        end
        if (w_capture) begin
          r_line[{w_data_word, 5'b00000} +: 32] <= hrdata;
          r_dbeat <= r_dbeat + 2'd1;
        end
        if (w_error) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    htrans = HTRANS_IDLE;
    hburst = HBURST_SINGLE;
    case (r_state)
      S_ADDR:  htrans = HTRANS_NONSEQ;
      S_BURST: htrans = HTRANS_SEQ;
      default: htrans = HTRANS_IDLE;
    endcase
    if (((r_state == S_ADDR) || (r_state == S_BURST) || (r_state == S_LAST)) && r_wrap) begin
      hburst = HBURST_WRAP4;
    end
  end

  assign haddr      = {r_word[29:2], w_addr_off, 2'b00};
  assign hwrite     = 1'b0;
  assign hsize      = HSIZE_WORD;
  assign req_ready  = (r_state == S_IDLE);
  assign fill_valid = (r_state == S_DONE);
  assign fill_err   = (r_state == S_DONE) && r_err;
  assign fill_addr  = r_fill_addr;
  assign line_data  = r_line;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_ahb_fill_sequencer.sv
// Directed bench for ahb_fill_sequencer: a table of zero-wait fills plus
// hand-written wait-state, error, reset and back-to-back sequences.
module tb_ahb_fill_sequencer;

  logic         clk;
  logic         rstn;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic         req_wrap;
  logic [31:0]  haddr;
  logic [1:0]   htrans;
  logic [2:0]   hburst;
  logic         hwrite;
  logic [2:0]   hsize;
  logic [31:0]  hrdata;
  logic         hready;
  logic         hresp;
  logic         fill_valid;
  logic [31:0]  fill_addr;
  logic [127:0] line_data;
  logic         fill_err;
  logic [2:0]   dbg_state;

  int checks   = 0;
  int failures = 0;

  ahb_fill_sequencer dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wrap   (req_wrap),
    .haddr      (haddr),
    .htrans     (htrans),
    .hburst     (hburst),
    .hwrite     (hwrite),
    .hsize      (hsize),
    .hrdata     (hrdata),
    .hready     (hready),
    .hresp      (hresp),
    .fill_valid (fill_valid),
    .fill_addr  (fill_addr),
    .line_data  (line_data),
    .fill_err   (fill_err),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          wrap;
    logic [31:0]   addr;
    logic [3:0][31:0] data;       // data[k] returned for beat k
    logic [3:0][31:0] exp_haddr;  // expected address of beat k
    logic [31:0]   exp_fill;
    logic [127:0]  exp_line;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [127:0] d,
                              input logic [127:0] h, input logic [31:0] fa, input logic [127:0] ln);
    vec_t v;
    v.wrap      = w;
    v.addr      = a;
    v.data      = d;
    v.exp_haddr = h;
    v.exp_fill  = fa;
    v.exp_line  = ln;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Check the current cycle, drive the slave response for it, advance to #1 after the next edge.
  task automatic step(input string tag, input logic rdy, input logic rsp, input logic [31:0] d,
                      input logic [1:0] et, input logic chk_a, input logic [31:0] ea, input logic ef);
    chk({tag, " htrans"}, 128'(htrans), 128'(et));
    if (chk_a) chk({tag, " haddr"}, 128'(haddr), 128'(ea));
    chk({tag, " fill_valid"}, 128'(fill_valid), 128'(ef));
    hready = rdy;
    hresp  = rsp;
    hrdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input string tag, input logic w, input logic [31:0] a);
    chk({tag, " req_ready"}, 128'(req_ready), 128'(1));
    req_valid = 1'b1;
    req_addr  = a;
    req_wrap  = w;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = ~a;
    req_wrap  = ~w;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    accept(tag, v.wrap, v.addr);
    chk({tag, " hburst"}, 128'(hburst), v.wrap ? 128'(3'b010) : 128'(3'b000));
    if (v.wrap) begin
      step({tag, " c1"}, 1'b1, 1'b0, 32'h0, 2'b10, 1'b1, v.exp_haddr[0], 1'b0);
      step({tag, " c2"}, 1'b1, 1'b0, v.data[0], 2'b11, 1'b1, v.exp_haddr[1], 1'b0);
      step({tag, " c3"}, 1'b1, 1'b0, v.data[1], 2'b11, 1'b1, v.exp_haddr[2], 1'b0);
      step({tag, " c4"}, 1'b1, 1'b0, v.data[2], 2'b11, 1'b1, v.exp_haddr[3], 1'b0);
      step({tag, " c5"}, 1'b1, 1'b0, v.data[3], 2'b00, 1'b1, v.exp_haddr[3], 1'b0);
    end else begin
      step({tag, " c1"}, 1'b1, 1'b0, 32'h0, 2'b10, 1'b1, v.exp_haddr[0], 1'b0);
      step({tag, " c2"}, 1'b1, 1'b0, v.data[0], 2'b00, 1'b1, v.exp_haddr[0], 1'b0);
    end
    chk({tag, " done fill_valid"}, 128'(fill_valid), 128'(1));
    chk({tag, " done fill_err"}, 128'(fill_err), 128'(0));
    chk({tag, " fill_addr"}, 128'(fill_addr), 128'(v.exp_fill));
    chk({tag, " line_data"}, line_data, v.exp_line);
    hrdata = 32'h0;
    @(posedge clk);
    #1;
    chk({tag, " post fill_valid"}, 128'(fill_valid), 128'(0));
    chk({tag, " post req_ready"}, 128'(req_ready), 128'(1));
    chk({tag, " post line_data"}, line_data, v.exp_line);
  endtask

  initial begin
    int acc_cnt;
    int fv_cnt;
    int ns_cnt;
    int err_cnt;
    int last_acc;

    vecs[0] = mk(1'b1, 32'h0000_1008,
                 {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000},
                 {32'h0000_1004, 32'h0000_1000, 32'h0000_100C, 32'h0000_1008},
                 32'h0000_1000,
                 {32'hA1A1_0001, 32'hA0A0_0000, 32'hA3A3_0003, 32'hA2A2_0002});
    vecs[1] = mk(1'b0, 32'h0000_2004,
                 {96'h0, 32'hDEAD_BEEF},
                 {96'h0, 32'h0000_2004},
                 32'h0000_2004,
                 {64'h0, 32'hDEAD_BEEF, 32'h0});
    vecs[2] = mk(1'b1, 32'h0000_3000,
                 {32'hB3B3_B3B3, 32'hB2B2_B2B2, 32'hB1B1_B1B1, 32'hB0B0_B0B0},
                 {32'h0000_300C, 32'h0000_3008, 32'h0000_3004, 32'h0000_3000},
                 32'h0000_3000,
                 {32'hB3B3_B3B3, 32'hB2B2_B2B2, 32'hB1B1_B1B1, 32'hB0B0_B0B0});
    vecs[3] = mk(1'b1, 32'h0000_400F,
                 {32'hC3C3_0303, 32'hC2C2_0202, 32'hC1C1_0101, 32'hC0C0_0000},
                 {32'h0000_4008, 32'h0000_4004, 32'h0000_4000, 32'h0000_400C},
                 32'h0000_4000,
                 {32'hC0C0_0000, 32'hC3C3_0303, 32'hC2C2_0202, 32'hC1C1_0101});
    vecs[4] = mk(1'b0, 32'h0000_5003,
                 {96'h0, 32'hE0E0_1234},
                 {96'h0, 32'h0000_5000},
                 32'h0000_5000,
                 {96'h0, 32'hE0E0_1234});
    vecs[5] = mk(1'b0, 32'hFFFF_FFFC,
                 {96'h0, 32'h0F0F_0F0F},
                 {96'h0, 32'hFFFF_FFFC},
                 32'hFFFF_FFFC,
                 {32'h0F0F_0F0F, 96'h0});
    vecs[6] = mk(1'b1, 32'hFFFF_FFF4,
                 {32'hD3D3_D3D3, 32'hD2D2_D2D2, 32'hD1D1_D1D1, 32'hD0D0_D0D0},
                 {32'hFFFF_FFF0, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'hFFFF_FFF4},
                 32'hFFFF_FFF0,
                 {32'hD2D2_D2D2, 32'hD1D1_D1D1, 32'hD0D0_D0D0, 32'hD3D3_D3D3});

    rstn      = 1'b0;
    req_valid = 1'b0;
    req_addr  = 32'h0;
    req_wrap  = 1'b0;
    hrdata    = 32'h0;
    hready    = 1'b1;
    hresp     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst htrans", 128'(htrans), 128'(0));
    chk("rst haddr", 128'(haddr), 128'(0));
    chk("rst hburst", 128'(hburst), 128'(0));
    chk("rst fill_valid", 128'(fill_valid), 128'(0));
    chk("rst fill_err", 128'(fill_err), 128'(0));
    chk("rst fill_addr", 128'(fill_addr), 128'(0));
    chk("rst line_data", line_data, 128'(0));
    chk("rst hwrite", 128'(hwrite), 128'(0));
    chk("rst hsize", 128'(hsize), 128'(3'b010));
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("rst release req_ready", 128'(req_ready), 128'(1));

    // Zero-wait fills from the table
    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // WRAP4 at 0x100C with two wait states during beat-1 data phase
    accept("ws", 1'b1, 32'h0000_100C);
    step("ws c1", 1'b1, 1'b0, 32'h0,         2'b10, 1'b1, 32'h0000_100C, 1'b0);
    step("ws c2", 1'b1, 1'b0, 32'h5000_0000, 2'b11, 1'b1, 32'h0000_1000, 1'b0);
    step("ws c3", 1'b0, 1'b0, 32'hBAD0_BAD0, 2'b11, 1'b1, 32'h0000_1004, 1'b0);
    step("ws c4", 1'b0, 1'b0, 32'hBAD1_BAD1, 2'b11, 1'b1, 32'h0000_1004, 1'b0);
    step("ws c5", 1'b1, 1'b0, 32'h5111_1111, 2'b11, 1'b1, 32'h0000_1004, 1'b0);
    step("ws c6", 1'b1, 1'b0, 32'h5222_2222, 2'b11, 1'b1, 32'h0000_1008, 1'b0);
    step("ws c7", 1'b1, 1'b0, 32'h5333_3333, 2'b00, 1'b1, 32'h0000_1008, 1'b0);
    chk("ws fill_valid", 128'(fill_valid), 128'(1));
    chk("ws fill_addr", 128'(fill_addr), 128'(32'h0000_1000));
    chk("ws line_data", line_data, {32'h5000_0000, 32'h5333_3333, 32'h5222_2222, 32'h5111_1111});
    chk("ws fill_err", 128'(fill_err), 128'(0));
    @(posedge clk);
    #1;

    // Error response during beat-2 data phase
    accept("er", 1'b1, 32'h0000_2000);
    step("er c1", 1'b1, 1'b0, 32'h0,         2'b10, 1'b1, 32'h0000_2000, 1'b0);
    step("er c2", 1'b1, 1'b0, 32'hE000_0000, 2'b11, 1'b1, 32'h0000_2004, 1'b0);
    step("er c3", 1'b1, 1'b0, 32'hE111_1111, 2'b11, 1'b1, 32'h0000_2008, 1'b0);
    step("er c4", 1'b0, 1'b1, 32'hBAD2_BAD2, 2'b11, 1'b1, 32'h0000_200C, 1'b0);
    step("er c5", 1'b1, 1'b1, 32'hBAD3_BAD3, 2'b00, 1'b0, 32'h0,         1'b0);
    chk("er fill_valid", 128'(fill_valid), 128'(1));
    chk("er fill_err", 128'(fill_err), 128'(1));
    chk("er line_data", line_data, {64'h0, 32'hE111_1111, 32'hE000_0000});
    chk("er htrans", 128'(htrans), 128'(0));
    hresp  = 1'b0;
    hready = 1'b1;
    @(posedge clk);
    #1;
    chk("er post req_ready", 128'(req_ready), 128'(1));
    chk("er post fill_valid", 128'(fill_valid), 128'(0));
    chk("er post fill_err", 128'(fill_err), 128'(0));

    // Reset pulsed during BURST
    accept("rb", 1'b1, 32'h0000_7008);
    step("rb c1", 1'b1, 1'b0, 32'h0,         2'b10, 1'b1, 32'h0000_7008, 1'b0);
    step("rb c2", 1'b1, 1'b0, 32'h7777_0000, 2'b11, 1'b1, 32'h0000_700C, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    chk("rb htrans", 128'(htrans), 128'(0));
    chk("rb haddr", 128'(haddr), 128'(0));
    chk("rb hburst", 128'(hburst), 128'(0));
    chk("rb fill_valid", 128'(fill_valid), 128'(0));
    chk("rb fill_err", 128'(fill_err), 128'(0));
    chk("rb fill_addr", 128'(fill_addr), 128'(0));
    chk("rb line_data", line_data, 128'(0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rb hold%0d fill_valid", i), 128'(fill_valid), 128'(0));
    end
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("rb release req_ready", 128'(req_ready), 128'(1));
    chk("rb release fill_valid", 128'(fill_valid), 128'(0));
    run_vec(vecs[0], "rb v0");

    // req_valid held high: one WRAP4 fill every 7 cycles, taken only in IDLE
    acc_cnt  = 0;
    fv_cnt   = 0;
    ns_cnt   = 0;
    err_cnt  = 0;
    last_acc = -1;
    hready    = 1'b1;
    hresp     = 1'b0;
    hrdata    = 32'h1234_5678;
    req_wrap  = 1'b1;
    req_addr  = 32'h0000_6000;
    req_valid = 1'b1;
    for (int i = 0; i < 21; i++) begin
      if (req_valid && req_ready) begin
        acc_cnt++;
        last_acc = i;
      end
      if (fill_valid) fv_cnt++;
      if (fill_err) err_cnt++;
      if (htrans == 2'b10) ns_cnt++;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    chk("b2b accepts", 128'(acc_cnt), 128'(3));
    chk("b2b fill_valid pulses", 128'(fv_cnt), 128'(3));
    chk("b2b nonseq count", 128'(ns_cnt), 128'(3));
    chk("b2b fill_err count", 128'(err_cnt), 128'(0));
    chk("b2b last accept cycle", 128'(last_acc), 128'(14));
    chk("b2b idle req_ready", 128'(req_ready), 128'(1));
    @(posedge clk);
    #1;
    chk("b2b quiet htrans", 128'(htrans), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_fill_sequencer.md
AHB_FILL_SEQUENCER -- requirements
Module: ahb_fill_sequencer

Interface
REQ-001 clk  in  1  clock; all state changes on rising edge.
REQ-002 rstn  in  1  reset, asynchronous, active-low.
REQ-003 req_valid  in  1  fetch request from I-cache miss logic.
REQ-004 req_ready  out  1  sequencer idle and accepting a request.
REQ-005 req_addr  in  32  fetch byte address; bits [1:0] ignored.
REQ-006 req_wrap  in  1  1 = WRAP4 line fill, 0 = SINGLE uncached word.
REQ-007 haddr  out  32  AHB address, always word aligned.
REQ-008 htrans  out  2  IDLE=2'b00, NONSEQ=2'b10, SEQ=2'b11.
REQ-009 hburst  out  3  SINGLE=3'b000, WRAP4=3'b010.
REQ-010 hwrite  out  1  constant 0; hsize out 3, constant 3'b010.
REQ-011 hrdata  in  32  AHB read data; hready in 1; hresp in 1 (1 = ERROR).
REQ-012 fill_valid  out  1  one-cycle completion pulse.
REQ-013 fill_addr  out  32  line address (WRAP4, low 4 bits 0) or word address (SINGLE).
REQ-014 line_data  out  128  word i in bits [32i+31:32i]; fill_err out 1, error flag valid with fill_valid.

Function
REQ-015 States SHALL be IDLE, ADDR, BURST, LAST, ERR, DONE.
REQ-016 req_ready SHALL be 1 only in IDLE; request accepted on edge with req_valid=1 and req_ready=1; addr/wrap latched then.
REQ-017 IDLE->ADDR on acceptance; in ADDR: htrans=NONSEQ, haddr={req_addr[31:2],2'b00}, hburst per req_wrap.
REQ-018 Address phase of a beat SHALL complete on an edge with hready=1; haddr/htrans/hburst SHALL hold while hready=0.
REQ-019 WRAP4 beat k (k=0..3) address SHALL be {A[31:4], (A[3:2]+k) mod 4, 2'b00}; beats 1..3 use htrans=SEQ; wrap never crosses the 16-byte line.
REQ-020 ADDR->BURST (WRAP4) or ADDR->LAST (SINGLE) when the first address phase completes; BURST->LAST when beat 3 address completes.
REQ-021 In LAST: htrans=IDLE, haddr holds last value; sequencer waits for final data.
REQ-022 Data for beat k SHALL be captured into line_data word (A[3:2]+k) mod 4 on the edge with hready=1 in its data phase (one beat after its address phase, pipelined).
REQ-023 SINGLE: data into word A[3:2]; other three words SHALL read 0.
REQ-024 LAST->DONE on capture of final data; DONE drives fill_valid=1 for exactly one cycle, then ->IDLE.
REQ-025 fill_addr SHALL be {A[31:4],4'b0} for WRAP4, {A[31:2],2'b00} for SINGLE; line_data/fill_addr hold until next acceptance.
REQ-026 Minimum latency, zero wait states: WRAP4 acceptance to fill_valid = 6 cycles; SINGLE = 3 cycles.
REQ-027 hresp=1 with hready=0 in any data phase SHALL move to ERR: next cycle htrans=IDLE (remaining beats cancelled), no capture of that beat.
REQ-028 ERR->DONE on the next hready=1; fill_valid=1 with fill_err=1; fill_err=0 on all other fill_valid pulses.
REQ-029 req_valid in any state other than IDLE SHALL be ignored (no queuing).
REQ-030 Address counter arithmetic SHALL be 2-bit modulo; offsets never carry into bit 4.

Reset
REQ-031 rstn=0 SHALL asynchronously force state IDLE, htrans=00, haddr=0, hburst=000, fill_valid=0, fill_err=0, fill_addr=0, line_data=0, beat counters=0.
REQ-032 Reset mid-burst SHALL abort with no fill_valid; first cycle after release req_ready=1.

Verification
REQ-033 WRAP4 req_addr=0x0000_1008, hready=1 always -> haddr 0x1008 NONSEQ, 0x100C/0x1000/0x1004 SEQ, then IDLE; fill_valid 6 cycles after acceptance, fill_addr=0x1000, words placed at indices 2,3,0,1.
REQ-034 SINGLE req_addr=0x0000_2004, hrdata=0xDEAD_BEEF -> one NONSEQ, hburst=000, fill_valid after 3 cycles, line_data word1=0xDEADBEEF, others 0.
REQ-035 WRAP4 at 0x100C with hready=0 for 2 cycles during beat-1 data phase -> haddr/htrans frozen, no capture until hready=1, fill_valid delayed by exactly 2 cycles, data correct.
REQ-036 hresp=1,hready=0 on beat 2 data phase then hresp=1,hready=1 -> htrans=IDLE next cycle, fill_valid=1 fill_err=1, return to IDLE, req_ready=1.
REQ-037 rstn pulsed low during BURST -> all outputs zero immediately, no fill_valid, new request after release completes normally.
REQ-038 req_valid held high continuously -> back-to-back fills, each accepted only in IDLE, one fill_valid per request.
